// File: rtl/alu_sequencer.sv
// Four-state issue/writeback sequencer: accepts one decoded ALU instruction, reads its
// operands, drives the external ALU for one cycle and commits or traps the result.
module alu_sequencer #(
    parameter int BUS_WIDTH     = 32,
    parameter bit TRAP_OVERFLOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [4:0]             instr_op,
    input  logic                   instr_imm,
    input  logic [4:0]             instr_rs,
    input  logic [4:0]             instr_rt,
    input  logic [4:0]             instr_rd,
    input  logic [BUS_WIDTH/2-1:0] instr_imm16,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [BUS_WIDTH-1:0]   rf_rdata1,
    input  logic [BUS_WIDTH-1:0]   rf_rdata2,
    output logic [BUS_WIDTH-1:0]   alu_in1,
    output logic [BUS_WIDTH-1:0]   alu_in2,
    output logic [4:0]             alu_op,
    output logic                   alu_imm,
    input  logic [BUS_WIDTH-1:0]   alu_out,
    input  logic                   alu_overflow,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [BUS_WIDTH-1:0]   rf_wdata,
    output logic                   exc_ovf,
    output logic                   exc_illegal,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    localparam int HW = BUS_WIDTH / 2;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

    state_t                state, state_next;
    logic [4:0]            op_q, rs_q, rt_q, rd_q;
    logic                  imm_q, ill_q, ovf_q;
    logic [HW-1:0]         imm16_q;
    logic [BUS_WIDTH-1:0]  res_q;
    logic                  is_addsub;

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE, so at most one
    // instruction is in flight and the decoder must hold its fields until then.
    assign is_addsub = (op_q == 5'h00) || (op_q == 5'h10);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            imm_q   <= 1'b0;
            ill_q   <= 1'b0;
            imm16_q <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && instr_valid) begin
                op_q    <= instr_op;
                imm_q   <= instr_imm;
                rs_q    <= instr_rs;
                rt_q    <= instr_rt;
                rd_q    <= instr_rd;
                imm16_q <= instr_imm16;
                ill_q   <= (instr_op > 5'h10);
            end
            if (state == EXEC) begin
                res_q <= alu_out;
                // The AND gate keeps an undefined overflow from non-add ops out of ovf_q.
                ovf_q <= is_addsub & alu_overflow;
            end
        end
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        rf_raddr1   = '0;
        rf_raddr2   = '0;
        alu_in1     = '0;
        alu_in2     = '0;
        alu_op      = '0;
        alu_imm     = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        exc_ovf     = 1'b0;
        exc_illegal = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = READ;
            end
            READ: begin
                rf_raddr1  = rs_q;
                rf_raddr2  = rt_q;
                state_next = EXEC;
            end
            EXEC: begin
                rf_raddr1  = rs_q;
                rf_raddr2  = rt_q;
                alu_in1    = rf_rdata1;
                alu_in2    = imm_q ? {{(BUS_WIDTH-HW){1'b0}}, imm16_q} : rf_rdata2;
                alu_op     = op_q;
                alu_imm    = imm_q;
                state_next = WB;
            end
            WB: begin
                if (ill_q) begin
                    exc_illegal = 1'b1;
                end else if (TRAP_OVERFLOW && ovf_q) begin
                    exc_ovf = 1'b1;
                end else if (rd_q != 5'd0) begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = res_q;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a trapping and a non-trapping instance run in lockstep
// against a behavioural register file and ALU; vectors carry hand-computed results.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [4:0]  instr_op, instr_rs, instr_rt, instr_rd;
    logic        instr_imm;
    logic [15:0] instr_imm16;
    logic [31:0] rf_rdata1, rf_rdata2;

    logic        instr_ready, rf_we, exc_ovf, exc_illegal, busy, alu_imm, alu_ovf;
    logic [4:0]  rf_raddr1, rf_raddr2, alu_op, rf_waddr;
    logic [31:0] alu_in1, alu_in2, alu_out, rf_wdata;
    logic [1:0]  state_dbg;

    logic        nt_ready, nt_we, nt_exc_ovf, nt_exc_ill, nt_busy, nt_alu_imm, nt_alu_ovf;
    logic [4:0]  nt_raddr1, nt_raddr2, nt_alu_op, nt_waddr;
    logic [31:0] nt_in1, nt_in2, nt_alu_out, nt_wdata;
    logic [1:0]  nt_state;

    logic [31:0] regs [32];
    int checks_total = 0;
    int checks_pass  = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: ADD 00, SUB 10, AND 01, OR 02, XOR 03, SLL 04, LTU 05.
    function automatic logic [32:0] alu_f(input logic [4:0] op, input logic imm,
                                          input logic [31:0] a, input logic [31:0] b_in);
        logic [31:0] b, r;
        logic        o;
        b = b_in;
        if (imm && (op == 5'h00 || op == 5'h10)) b = {{16{b_in[15]}}, b_in[15:0]};
        o = 1'bx;
        r = '0;
        case (op)
            5'h00: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            5'h10: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            5'h01: r = a & b;
            5'h02: r = a | b;
            5'h03: r = a ^ b;
            5'h04: r = b << a[4:0];
            5'h05: r = {31'b0, a < b};
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    assign {alu_ovf, alu_out}       = alu_f(alu_op, alu_imm, alu_in1, alu_in2);
    assign {nt_alu_ovf, nt_alu_out} = alu_f(nt_alu_op, nt_alu_imm, nt_in1, nt_in2);

    always @(posedge clk) begin
        rf_rdata1 <= regs[rf_raddr1];
        rf_rdata2 <= regs[rf_raddr2];
        if (rf_we) regs[rf_waddr] <= rf_wdata;
    end

    alu_sequencer #(.BUS_WIDTH(32), .TRAP_OVERFLOW(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_imm(instr_imm), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .instr_rd(instr_rd), .instr_imm16(instr_imm16), .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_imm(alu_imm),
        .alu_out(alu_out), .alu_overflow(alu_ovf), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .exc_ovf(exc_ovf), .exc_illegal(exc_illegal), .busy(busy),
        .state_dbg(state_dbg)
    );

    alu_sequencer #(.BUS_WIDTH(32), .TRAP_OVERFLOW(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(nt_ready),
        .instr_op(instr_op), .instr_imm(instr_imm), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .instr_rd(instr_rd), .instr_imm16(instr_imm16), .rf_raddr1(nt_raddr1),
        .rf_raddr2(nt_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_in1(nt_in1), .alu_in2(nt_in2), .alu_op(nt_alu_op), .alu_imm(nt_alu_imm),
        .alu_out(nt_alu_out), .alu_overflow(nt_alu_ovf), .rf_we(nt_we), .rf_waddr(nt_waddr),
        .rf_wdata(nt_wdata), .exc_ovf(nt_exc_ovf), .exc_illegal(nt_exc_ill), .busy(nt_busy),
        .state_dbg(nt_state)
    );

    typedef struct {
        logic [4:0]  op;
        logic        imm;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm16;
        logic        we;
        logic [31:0] wdata;
        logic        ovf;
        logic        ill;
        logic        nt_we;
        logic [31:0] nt_wdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else checks_pass++;
    endtask

    task automatic drive(input vec_t v);
        instr_valid = 1'b1;
        instr_op    = v.op;
        instr_imm   = v.imm;
        instr_rs    = v.rs;
        instr_rt    = v.rt;
        instr_rd    = v.rd;
        instr_imm16 = v.imm16;
    endtask

    task automatic scramble();
        instr_op    = 5'($urandom_range(0, 31));
        instr_imm   = 1'($urandom_range(0, 1));
        instr_rs    = 5'($urandom_range(0, 31));
        instr_rt    = 5'($urandom_range(0, 31));
        instr_rd    = 5'($urandom_range(0, 31));
        instr_imm16 = 16'($urandom_range(0, 65535));
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic imm, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [15:0] imm16, input logic we,
                                input logic [31:0] wdata, input logic ovf, input logic ill,
                                input logic nt_we, input logic [31:0] nt_wdata);
        vec_t v;
        v.op = op; v.imm = imm; v.rs = rs; v.rt = rt; v.rd = rd; v.imm16 = imm16;
        v.we = we; v.wdata = wdata; v.ovf = ovf; v.ill = ill;
        v.nt_we = nt_we; v.nt_wdata = nt_wdata;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int n = 0;
        logic [31:0] exp_in2;
        while (!instr_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_ready_wait"}, {31'b0, instr_ready}, 32'd1);
        drive(v);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        scramble();
        chk({tag, "_read_state"}, {30'b0, state_dbg}, 32'd1);
        chk({tag, "_read_ready"}, {31'b0, instr_ready}, 32'd0);
        chk({tag, "_nt_busy"}, {31'b0, nt_busy}, 32'd1);
        chk({tag, "_raddr1"}, {27'b0, rf_raddr1}, {27'b0, v.rs});
        chk({tag, "_raddr2"}, {27'b0, rf_raddr2}, {27'b0, v.rt});
        @(posedge clk); #1;
        exp_in2 = v.imm ? {16'b0, v.imm16} : regs[v.rt];
        chk({tag, "_alu_in1"}, alu_in1, regs[v.rs]);
        chk({tag, "_alu_in2"}, alu_in2, exp_in2);
        chk({tag, "_alu_op"}, {27'b0, alu_op}, {27'b0, v.op});
        chk({tag, "_alu_imm"}, {31'b0, alu_imm}, {31'b0, v.imm});
        chk({tag, "_exec_we"}, {31'b0, rf_we}, 32'd0);
        chk({tag, "_nt_ctl"}, {nt_state, nt_ready, nt_raddr1, nt_raddr2, nt_alu_op, nt_alu_imm},
            {2'd2, 1'b0, v.rs, v.rt, v.op, v.imm});
        @(posedge clk); #1;
        chk({tag, "_wb_state"}, {30'b0, state_dbg}, 32'd3);
        chk({tag, "_we"}, {31'b0, rf_we}, {31'b0, v.we});
        chk({tag, "_exc_ovf"}, {31'b0, exc_ovf}, {31'b0, v.ovf});
        chk({tag, "_exc_ill"}, {31'b0, exc_illegal}, {31'b0, v.ill});
        if (v.we) begin
            chk({tag, "_waddr"}, {27'b0, rf_waddr}, {27'b0, v.rd});
            chk({tag, "_wdata"}, rf_wdata, v.wdata);
        end
        chk({tag, "_nt_we"}, {31'b0, nt_we}, {31'b0, v.nt_we});
        chk({tag, "_nt_exc"}, {30'b0, nt_exc_ovf, nt_exc_ill}, {30'b0, 1'b0, v.ill});
        if (v.nt_we) begin
            chk({tag, "_nt_waddr"}, {27'b0, nt_waddr}, {27'b0, v.rd});
            chk({tag, "_nt_wdata"}, nt_wdata, v.nt_wdata);
        end
        @(posedge clk); #1;
        chk({tag, "_idle"}, {29'b0, busy, instr_ready, rf_we}, {29'b0, 1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1] = 32'd5;        regs[2] = 32'd7;         regs[4] = 32'h7FFF_FFFF;
        regs[10] = 32'd10;      regs[11] = 32'd3;        regs[12] = 32'h0000_F0F0;
        regs[13] = 32'h0000_0FF0; regs[14] = 32'd4;      regs[15] = 32'd1;
        regs[16] = 32'hFFFF_FFFF;

        //         op     imm  rs  rt  rd  imm16     we  wdata          ovf ill nt_we nt_wdata
        vecs[0] = mk(5'h00, 0, 1,  2,  3,  16'h0000, 1, 32'd12,        0,  0,  1, 32'd12);
        vecs[1] = mk(5'h00, 1, 4,  0,  5,  16'h0001, 0, 32'd0,         1,  0,  1, 32'h8000_0000);
        vecs[2] = mk(5'h01, 0, 1,  2,  0,  16'h0000, 0, 32'd0,         0,  0,  0, 32'd0);
        vecs[3] = mk(5'h15, 0, 1,  2,  8,  16'h0000, 0, 32'd0,         0,  1,  0, 32'd0);
        vecs[4] = mk(5'h04, 0, 14, 15, 9,  16'h0000, 1, 32'h10,        0,  0,  1, 32'h10);
        vecs[5] = mk(5'h05, 0, 15, 16, 17, 16'h0000, 1, 32'd1,         0,  0,  1, 32'd1);
        vecs[6] = mk(5'h02, 1, 12, 0,  18, 16'h000F, 1, 32'h0000_F0FF, 0,  0,  1, 32'h0000_F0FF);
        vecs[7] = mk(5'h00, 0, 3,  1,  19, 16'h0000, 1, 32'd17,        0,  0,  1, 32'd17);

        // Reset wins over a simultaneous valid.
        rst = 1'b1;
        drive(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {30'b0, state_dbg}, 32'd0);
        chk("rst_ready_busy", {30'b0, instr_ready, busy}, {30'b0, 2'b10});
        chk("rst_outputs", {rf_we, exc_ovf, exc_illegal, alu_op, rf_raddr1, rf_waddr},
            '0);
        chk("rst_alu_in", alu_in1 | alu_in2 | rf_wdata, 32'd0);
        instr_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", {30'b0, state_dbg}, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));
        chk("rf_r3", regs[3], 32'd12);
        chk("rf_r0", regs[0], 32'd0);
        chk("rf_r5_trapped", regs[5], 32'd0);
        chk("rf_r8_illegal", regs[8], 32'd0);

        // Back-to-back with valid held high: SUB then XOR.
        drive(mk(5'h10, 0, 10, 11, 6, 16'h0, 1, 32'd7, 0, 0, 1, 32'd7));
        @(posedge clk); #1;
        drive(mk(5'h03, 0, 12, 13, 7, 16'h0, 1, 32'hFF00, 0, 0, 1, 32'hFF00));
        chk("b2b_t1_ready", {31'b0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_t2_ready", {31'b0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_t3_ready", {31'b0, instr_ready}, 32'd0);
        chk("b2b_sub_we", {31'b0, rf_we}, 32'd1);
        chk("b2b_sub_waddr", {27'b0, rf_waddr}, 32'd6);
        chk("b2b_sub_wdata", rf_wdata, 32'd7);
        @(posedge clk); #1;
        chk("b2b_t4_ready", {31'b0, instr_ready}, 32'd1);
        chk("b2b_t4_we", {31'b0, rf_we}, 32'd0);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        scramble();
        chk("b2b_t5_ready", {31'b0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_t6_we", {31'b0, rf_we}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_xor_we", {31'b0, rf_we}, 32'd1);
        chk("b2b_xor_waddr", {27'b0, rf_waddr}, 32'd7);
        chk("b2b_xor_wdata", rf_wdata, 32'h0000_FF00);
        @(posedge clk); #1;

        // Reset during EXEC aborts the instruction.
        drive(mk(5'h00, 0, 1, 2, 20, 16'h0, 1, 32'd12, 0, 0, 1, 32'd12));
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_exec", {30'b0, state_dbg}, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_state", {30'b0, state_dbg}, 32'd0);
        chk("abort_ready", {31'b0, instr_ready}, 32'd1);
        chk("abort_we", {29'b0, rf_we, exc_ovf, exc_illegal}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_quiet%0d", k), {29'b0, rf_we, exc_ovf, exc_illegal}, 32'd0);
        end
        chk("abort_r20", regs[20], 32'd0);
        run_vec(mk(5'h00, 0, 1, 2, 21, 16'h0, 1, 32'd12, 0, 0, 1, 32'd12), "post_abort");
        chk("rf_r21", regs[21], 32'd12);

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
